gbuf_arbiter: RTL and testbench

Arbitrates the single-port global buffer between NUM_REQ requesters: DMA controller, instruction scheduler and host interface. It uses round-robin priority with optional burst locking and a bounded burst length. Accepted accesses are muxed onto the buffer port, and the 1-cycle read data is routed back to the issuing requester. The block sits between those three masters and global_buffer, replacing their direct buffer wiring.

---
 rtl/gbuf_arbiter_pkg.sv | 14 +
 rtl/gbuf_arbiter_rr_priority_picker.sv | 38 +++
 rtl/gbuf_arbiter.sv | 155 +++++++++++++++
 tb/tb_gbuf_arbiter.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gbuf_arbiter_pkg.sv
// Shared constants for the global-buffer arbiter:
// requester count, requester indices and FSM state encodings.
package gbuf_arbiter_pkg;

  localparam int GBUF_NUM_REQ = 3;

  localparam int REQ_DMA   = 0;
  localparam int REQ_SCHED = 1;
  localparam int REQ_HOST  = 2;

  localparam logic [0:0] ARB_IDLE  = 1'b0;
  localparam logic [0:0] ARB_OWNED = 1'b1;

endpackage

// File: rtl/gbuf_arbiter_rr_priority_picker.sv
// Rotating-priority one-hot picker: first set bit of req_i
// at or above ptr_i, wrapping modulo N.
// Ports: req_i request vector, ptr_i start index,
//        gnt_o one-hot grant, idx_o grant index, any_o any request.
module rr_priority_picker #(
  parameter int N  = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  logic found;
  int   j;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr_i) + k;
      if (j >= N) j = j - N;
      for (int i = 0; i < N; i++) begin
        if (!found && (i == j) && req_i[i]) begin
          found    = 1'b1;
          gnt_o[i] = 1'b1;
          idx_o    = IW'(i);
        end
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/gbuf_arbiter.sv
// Round-robin arbiter for the single-port global buffer with
// burst locking (bounded by MAX_BURST) and 1-cycle read return.
// Ports: req_* per-requester valid/ready/we/lock/addr/wdata,
//        rsp_* read return, buf_* buffer port, grant_id, busy.
module gbuf_arbiter
  import gbuf_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int NUM_REQ    = GBUF_NUM_REQ,
  parameter int MAX_BURST  = 16,
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CW = $clog2(MAX_BURST + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ-1:0]            req_lock,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          buf_ce,
  output logic                          buf_we,
  output logic [ADDR_WIDTH-1:0]         buf_addr,
  output logic [DATA_WIDTH-1:0]         buf_wdata,
  input  logic [DATA_WIDTH-1:0]         buf_rdata,
  output logic [IW-1:0]                 grant_id,
  output logic                          busy
);

  logic [0:0]         state_q, state_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [CW-1:0]      beat_q, beat_d;
  logic [IW-1:0]      gid_q, gid_d;
  logic [NUM_REQ-1:0] rsp_q, rsp_d;

  logic [NUM_REQ-1:0] own_mask;
  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] pick_gnt;
  logic [IW-1:0]      pick_idx;
  logic               pick_any;
  logic               xfer;
  logic               win_we;
  logic               win_lock;
  logic               others;
  logic               owner_valid;
  logic [CW-1:0]      beat_inc;
  logic [IW-1:0]      nxt_ptr;

  // The owner is always the last granted requester.
  assign own_mask = NUM_REQ'(1) << gid_q;
  assign elig     = (state_q == ARB_OWNED)
                  ? (req_valid & own_mask)
                  : req_valid;

  rr_priority_picker #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .req_i (elig),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  assign xfer        = pick_any & ~rst;
  assign req_ready   = rst ? '0 : pick_gnt;
  assign win_we      = req_we[pick_idx];
  assign win_lock    = req_lock[pick_idx];
  assign others      = |(req_valid & ~own_mask);
  assign owner_valid = |(req_valid & own_mask);
  assign beat_inc    = beat_q + CW'(1);
  assign nxt_ptr     = (pick_idx == IW'(NUM_REQ - 1))
                     ? '0
                     : pick_idx + IW'(1);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    beat_d  = beat_q;
    gid_d   = gid_q;
    rsp_d   = '0;
    if (xfer) begin
      ptr_d = nxt_ptr;
      gid_d = pick_idx;
      if (!win_we) rsp_d = pick_gnt;
    end
    unique case (state_q)
      ARB_IDLE: begin
        if (xfer && win_lock) begin
          state_d = ARB_OWNED;
          beat_d  = CW'(1);
        end
      end
      ARB_OWNED: begin
        if (!owner_valid) begin
          state_d = ARB_IDLE;
          beat_d  = '0;
        end else if (xfer) begin
          if (!win_lock) begin
            state_d = ARB_IDLE;
            beat_d  = '0;
          end else if (beat_inc == CW'(MAX_BURST)) begin
            // Burst limit: rotate out only if someone waits.
            if (others) begin
              state_d = ARB_IDLE;
              beat_d  = '0;
            end else begin
              beat_d = CW'(1);
            end
          end else begin
            beat_d = beat_inc;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      ptr_q   <= '0;
      beat_q  <= '0;
      gid_q   <= '0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      beat_q  <= beat_d;
      gid_q   <= gid_d;
      rsp_q   <= rsp_d;
    end
  end

  // A response in flight when reset rises is dropped at once.
  assign rsp_valid = rsp_q & ~{NUM_REQ{rst}};
  assign rsp_rdata = buf_rdata;
  assign grant_id  = gid_q;
  assign busy      = (state_q == ARB_OWNED);

  assign buf_ce    = xfer;
  assign buf_we    = xfer & win_we;
  assign buf_addr  = xfer
                   ? req_addr[pick_idx*ADDR_WIDTH +: ADDR_WIDTH]
                   : '0;
  assign buf_wdata = xfer
                   ? req_wdata[pick_idx*DATA_WIDTH +: DATA_WIDTH]
                   : '0;

endmodule

// File: tb/tb_gbuf_arbiter.sv
// Scoreboard bench for gbuf_arbiter: directed grant/response
// vectors plus a randomised phase against a buffer model.
module tb_gbuf_arbiter;
  import gbuf_arbiter_pkg::*;

  localparam int DW = 32;
  localparam int AW = 16;
  localparam int N  = 3;
  localparam int MB = 16;
  localparam int WAIT_MAX = (N - 1) * MB + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [N-1:0]    req_valid, req_ready, req_we, req_lock;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            buf_ce, buf_we;
  logic [AW-1:0]   buf_addr;
  logic [DW-1:0]   buf_wdata;
  logic [DW-1:0]   buf_rdata;
  logic [1:0]      grant_id;
  logic            busy;

  gbuf_arbiter #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .NUM_REQ    (N),
    .MAX_BURST  (MB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_lock  (req_lock),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .buf_ce    (buf_ce),
    .buf_we    (buf_we),
    .buf_addr  (buf_addr),
    .buf_wdata (buf_wdata),
    .buf_rdata (buf_rdata),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  typedef struct {
    bit            ce;
    int            id;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    bit            bsy;
  } cyc_t;

  typedef struct {
    int            id;
    logic [DW-1:0] d;
    int            cy;
  } rsp_t;

  cyc_t cq[$];
  rsp_t rq[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit rnd   = 1'b0;
  bit discard = 1'b0;

  bit            v[N], w[N], l[N];
  logic [AW-1:0] a[N];
  logic [DW-1:0] d[N];

  logic [DW-1:0] mem[0:255];
  logic [DW-1:0] shd[0:255];

  always @(posedge clk) cyc <= cyc + 1;

  // Buffer model: registered read, 1-cycle latency.
  initial begin
    bit            mce, mwe;
    logic [7:0]    ma;
    logic [DW-1:0] mwd;
    buf_rdata = '0;
    for (int i = 0; i < 256; i++)
      mem[i] = 32'hC0DE_0000 | i;
    forever begin
      @(negedge clk);
      mce = buf_ce;
      mwe = buf_we;
      ma  = buf_addr[7:0];
      mwd = buf_wdata;
      @(posedge clk);
      if (mce) begin
        if (mwe) mem[ma] = mwd;
        else     buf_rdata = mem[ma];
      end
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = v[i];
      req_we[i]    = w[i];
      req_lock[i]  = l[i];
      req_addr[i*AW +: AW]  = a[i];
      req_wdata[i*DW +: DW] = d[i];
    end
  endtask

  task automatic set(input int i, input bit vv,
                     input bit ww, input bit ll,
                     input logic [AW-1:0] aa,
                     input logic [DW-1:0] dd);
    v[i] = vv;
    w[i] = ww;
    l[i] = ll;
    a[i] = aa;
    d[i] = dd;
  endtask

  task automatic clr();
    for (int i = 0; i < N; i++) set(i, 0, 0, 0, '0, '0);
  endtask

  // One directed cycle: expected grant (or none) and,
  // for a read, the expected response one cycle later.
  task automatic step(input bit ce, input int id,
                      input bit bsy,
                      input logic [DW-1:0] rd);
    cyc_t e;
    rsp_t r;
    drive();
    e.ce   = ce;
    e.id   = id;
    e.we   = w[id];
    e.addr = a[id];
    e.wd   = d[id];
    e.bsy  = bsy;
    cq.push_back(e);
    if (ce && !w[id] && !discard) begin
      r.id = id;
      r.d  = rd;
      r.cy = cyc + 1;
      rq.push_back(r);
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor
  initial begin
    cyc_t          e;
    rsp_t          r;
    logic [N-1:0]  er;
    int            wi;
    int            wt[N];
    logic [AW-1:0] wa;
    for (int i = 0; i < 256; i++)
      shd[i] = 32'hC0DE_0000 | i;
    for (int i = 0; i < N; i++) wt[i] = 0;
    forever begin
      @(negedge clk);
      wi = -1;
      for (int i = 0; i < N; i++)
        if (req_ready[i]) wi = i;

      if (rst) begin
        total++;
        if (rsp_valid !== '0 || req_ready !== '0 ||
            buf_ce !== 1'b0) begin
          bad++;
          $display("FAIL reset_outputs: rsp=%b rdy=%b ce=%b want 0",
                   rsp_valid, req_ready, buf_ce);
        end
      end

      if (cq.size() > 0) begin
        e  = cq.pop_front();
        er = e.ce ? (N'(1) << e.id) : '0;
        total++;
        if (req_ready !== er || buf_ce !== e.ce ||
            busy !== e.bsy ||
            (e.ce && (buf_we !== e.we ||
                      buf_addr !== e.addr ||
                      (e.we && buf_wdata !== e.wd)))) begin
          bad++;
          $display({"FAIL grant cyc=%0d: rdy=%b ce=%b we=%b",
                    " addr=%h wd=%h busy=%b; want rdy=%b",
                    " ce=%b we=%b addr=%h wd=%h busy=%b"},
                   cyc, req_ready, buf_ce, buf_we, buf_addr,
                   buf_wdata, busy, er, e.ce, e.we, e.addr,
                   e.wd, e.bsy);
        end
      end else if (!rnd && buf_ce) begin
        total++;
        bad++;
        $display("FAIL stray_grant cyc=%0d: rdy=%b want none",
                 cyc, req_ready);
      end

      if (rnd) begin
        total++;
        if ($countones(req_ready) > 1 ||
            (buf_ce !== (req_ready != '0))) begin
          bad++;
          $display("FAIL onehot cyc=%0d: rdy=%b ce=%b",
                   cyc, req_ready, buf_ce);
        end
        for (int i = 0; i < N; i++) begin
          if (req_valid[i] && !req_ready[i]) wt[i]++;
          else wt[i] = 0;
        end
        total++;
        for (int i = 0; i < N; i++) begin
          if (wt[i] > WAIT_MAX) begin
            bad++;
            $display("FAIL starve req%0d: waited %0d want <= %0d",
                     i, wt[i], WAIT_MAX);
            wt[i] = 0;
          end
        end
        if (wi >= 0 && !req_we[wi]) begin
          wa   = req_addr[wi*AW +: AW];
          r.id = wi;
          r.d  = shd[wa[7:0]];
          r.cy = cyc + 1;
          rq.push_back(r);
        end
      end

      if (wi >= 0 && req_we[wi]) begin
        wa = req_addr[wi*AW +: AW];
        shd[wa[7:0]] = req_wdata[wi*DW +: DW];
      end

      if (rsp_valid !== '0) begin
        total++;
        if (rq.size() == 0) begin
          bad++;
          $display("FAIL rsp_unexpected cyc=%0d: rsp=%b want none",
                   cyc, rsp_valid);
        end else begin
          r  = rq.pop_front();
          er = N'(1) << r.id;
          if (rsp_valid !== er || rsp_rdata !== r.d ||
              cyc != r.cy) begin
            bad++;
            $display({"FAIL rsp cyc=%0d: rsp=%b data=%h;",
                      " want rsp=%b data=%h cyc=%0d"},
                     cyc, rsp_valid, rsp_rdata, er, r.d, r.cy);
          end
        end
      end
    end
  end

  initial begin
    logic [N-1:0] acc;
    rst = 1'b1;
    clr();
    drive();
    repeat (2) @(posedge clk);
    #1;

    // Reset with all requesters pending: nothing granted.
    for (int i = 0; i < N; i++)
      set(i, 1, 0, 0, AW'(16 * (i + 1)), '0);
    step(0, 0, 0, '0);
    step(0, 0, 0, '0);
    chk("reset_gid", 32'(grant_id), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_rsp", 32'(rsp_valid), 0);
    rst = 1'b0;

    // Unlocked reads from all three: plain rotation.
    for (int k = 0; k < 6; k++)
      step(1, k % 3, 0, 32'hC0DE_0000 | (16 * (k % 3 + 1)));
    chk("rot_gid", 32'(grant_id), 2);

    // Locked 20-beat write burst vs a waiting reader.
    clr();
    for (int b = 0; b < 16; b++) begin
      set(1, 1, 1, 1, AW'(16'h80 + b), 32'h1000_0000 + b);
      set(2, 1, 0, 0, 16'h0030, '0);
      step(1, 1, b != 0, '0);
    end
    set(1, 1, 1, 1, 16'h0090, 32'h1000_0010);
    step(1, 2, 0, 32'hC0DE_0030);
    set(2, 0, 0, 0, '0, '0);
    for (int b = 16; b < 20; b++) begin
      set(1, 1, 1, b != 19, AW'(16'h80 + b),
          32'h1000_0000 + b);
      step(1, 1, b > 16, '0);
    end
    chk("mem_burst_last", mem[8'h93], 32'h1000_0013);

    // 40-beat locked burst without competition.
    clr();
    for (int b = 0; b < 40; b++) begin
      set(0, 1, 1, b != 39, AW'(16'hC0 + b),
          32'h2000_0000 + b);
      step(1, 0, b != 0, '0);
    end
    clr();
    step(0, 0, 0, '0);
    chk("long_gid", 32'(grant_id), 0);
    chk("mem_long_last", mem[8'hE7], 32'h2000_0027);

    // Owner drops valid while locked.
    set(1, 1, 1, 1, 16'h0040, 32'h3000_0000);
    step(1, 1, 0, '0);
    set(1, 1, 1, 1, 16'h0041, 32'h3000_0001);
    step(1, 1, 1, '0);
    set(1, 0, 0, 0, '0, '0);
    set(0, 1, 0, 0, 16'h0010, '0);
    set(2, 1, 0, 0, 16'h0020, '0);
    step(0, 0, 1, '0);
    step(1, 2, 0, 32'hC0DE_0020);
    set(2, 0, 0, 0, '0, '0);
    step(1, 0, 0, 32'hC0DE_0010);
    clr();
    step(0, 0, 0, '0);

    // Reset right after a read accept.
    set(1, 1, 0, 0, 16'h0030, '0);
    discard = 1'b1;
    step(1, 1, 0, '0);
    discard = 1'b0;
    clr();
    rst = 1'b1;
    set(0, 1, 0, 0, 16'h0010, '0);
    set(2, 1, 0, 0, 16'h0020, '0);
    step(0, 0, 0, '0);
    step(0, 0, 0, '0);
    chk("rst2_gid", 32'(grant_id), 0);
    rst = 1'b0;
    step(1, 0, 0, 32'hC0DE_0010);
    set(0, 0, 0, 0, '0, '0);
    step(1, 2, 0, 32'hC0DE_0020);
    clr();
    step(0, 0, 0, '0);

    // Randomised traffic; requests hold until accepted.
    rnd = 1'b1;
    acc = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!v[i] || acc[i])
          set(i, $urandom_range(0, 99) < 60,
              1'($urandom_range(0, 1)),
              $urandom_range(0, 3) != 0,
              AW'($urandom_range(0, 15)),
              $urandom);
      end
      drive();
      @(negedge clk);
      acc = req_ready;
      @(posedge clk);
      #1;
    end
    rnd = 1'b0;
    clr();
    drive();
    repeat (3) @(posedge clk);
    #1;
    chk("rsp_queue_empty", 32'(rq.size()), 0);
    chk("cyc_queue_empty", 32'(cq.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
